// File: rtl/seq_divider_8bit_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// default operand width and the quotient reported on a divide-by-zero.
package seq_divider_8bit_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Wide enough for any practical WIDTH; sliced down at the point of use.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_8bit_addsub.sv
// Combinational W-bit add/subtract: B is inverted by sub and sub is the carry-in,
// so sub=1 yields a - b in two's complement.
module addsub_nbit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic [W-1:0] b_x;

  assign b_x = b ^ {W{sub}};
  assign y   = a + b_x + W'(sub);

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// single shared (WIDTH+1)-bit subtractor, with a start/busy/done handshake.
module seq_divider_8bit
  import seq_divider_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // Q holds the not-yet-consumed dividend bits in its top and the growing
  // quotient in its bottom; its MSB feeds the partial remainder each step.
  assign r_shift = {r_work, q_work[WIDTH-1]};

  addsub_nbit #(.W(WIDTH + 1)) u_sub (
    .a   (r_shift),
    .b   ({1'b0, dvs}),
    .sub (1'b1),
    .y   (trial)
  );

  assign trial_neg = trial[WIDTH];
  assign q_next    = {q_work[WIDTH-2:0], ~trial_neg};
  // A stored remainder is always < divisor, so it fits in WIDTH bits.
  assign r_next    = trial_neg ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      q_work <= dividend;
      r_work <= '0;
      dvs    <= divisor;
    end else if (state == ST_RUN) begin
      q_work <= q_next;
      r_work <= r_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count       <= '0;
            div_by_zero <= 1'b0;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A zero divisor is resolved on the first RUN cycle, before any shift.
          if (dvs == '0) begin
            quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            remainder   <= q_work;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            count <= count + 1'b1;
            if (count == LAST) begin
              quotient  <= q_next;
              remainder <= r_next;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
